// File: rtl/cube_move_scheduler_pkg.sv
// Shared types and constants for the cube move scheduler: faces, moves, keycodes,
// scheduler states and scramble LFSR constants.
package cube_pkg;

  localparam int unsigned KEY_W  = 8;
  localparam int unsigned LFSR_W = 16;

  typedef enum logic [2:0] {
    U = 3'd0,
    D = 3'd1,
    L = 3'd2,
    R = 3'd3,
    F = 3'd4,
    B = 3'd5
  } face_t;

  typedef struct packed {
    logic  ccw;
    face_t face;
  } move_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VB = 2'd1,
    S_ACTIVE  = 2'd2
  } sched_state_t;

  localparam logic [KEY_W-1:0] KEY_NONE = 8'h00;
  localparam logic [KEY_W-1:0] KEY_U    = 8'h18;
  localparam logic [KEY_W-1:0] KEY_D    = 8'h07;
  localparam logic [KEY_W-1:0] KEY_L    = 8'h0F;
  localparam logic [KEY_W-1:0] KEY_R    = 8'h15;
  localparam logic [KEY_W-1:0] KEY_F    = 8'h09;
  localparam logic [KEY_W-1:0] KEY_B    = 8'h05;
  localparam logic [KEY_W-1:0] KEY_1    = 8'h1E;
  localparam logic [KEY_W-1:0] KEY_2    = 8'h1F;
  localparam logic [KEY_W-1:0] KEY_3    = 8'h20;
  localparam logic [KEY_W-1:0] KEY_4    = 8'h21;
  localparam logic [KEY_W-1:0] KEY_5    = 8'h22;
  localparam logic [KEY_W-1:0] KEY_6    = 8'h23;
  localparam logic [KEY_W-1:0] KEY_ESC  = 8'h29;

  // Taps 16,14,13,11 expressed as a mask on bits 15,13,12,10 of a left-shifting register
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic logic key_is_move(input logic [KEY_W-1:0] kc);
    case (kc)
      KEY_U, KEY_D, KEY_L, KEY_R, KEY_F, KEY_B,
      KEY_1, KEY_2, KEY_3, KEY_4, KEY_5, KEY_6: key_is_move = 1'b1;
      default:                                  key_is_move = 1'b0;
    endcase
  endfunction

  function automatic move_t key_to_move(input logic [KEY_W-1:0] kc);
    move_t m;
    m = '{ccw: 1'b0, face: U};
    case (kc)
      KEY_U:   m = '{ccw: 1'b0, face: U};
      KEY_D:   m = '{ccw: 1'b0, face: D};
      KEY_L:   m = '{ccw: 1'b0, face: L};
      KEY_R:   m = '{ccw: 1'b0, face: R};
      KEY_F:   m = '{ccw: 1'b0, face: F};
      KEY_B:   m = '{ccw: 1'b0, face: B};
      KEY_1:   m = '{ccw: 1'b1, face: U};
      KEY_2:   m = '{ccw: 1'b1, face: D};
      KEY_3:   m = '{ccw: 1'b1, face: L};
      KEY_4:   m = '{ccw: 1'b1, face: R};
      KEY_5:   m = '{ccw: 1'b1, face: F};
      KEY_6:   m = '{ccw: 1'b1, face: B};
      default: m = '{ccw: 1'b0, face: U};
    endcase
    return m;
  endfunction

  // Folds the 3-bit random value 6/7 back onto faces U/D
  function automatic face_t lfsr_face(input logic [2:0] v);
    return (v < 3'd6) ? face_t'(v) : face_t'(v - 3'd6);
  endfunction

endpackage

// File: rtl/cube_move_scheduler_if.sv
// Move launch handshake between the scheduler (master) and the rotation datapath (slave).
interface cube_move_scheduler_if;
  import cube_pkg::*;

  logic  move_start;
  face_t move_face;
  logic  move_ccw;
  logic  move_done;

  modport master (output move_start, output move_face, output move_ccw, input move_done);
  modport slave  (input move_start, input move_face, input move_ccw, output move_done);
endinterface

// File: rtl/cube_move_scheduler_move_fifo.sv
// Registered move queue with push/pop/flush; a push while full is accepted only alongside a pop.
module move_fifo
  import cube_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  move_t                       din,
  input  logic                        pop,
  input  logic                        flush,
  output move_t                       head_c,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        full_c,
  output logic                        empty_c,
  output logic                        drop_c
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  move_t         mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop_c;
  logic          do_push_c;

  assign full_c    = (count == CW'(FIFO_DEPTH));
  assign empty_c   = (count == '0);
  assign do_pop_c  = pop & ~empty_c;
  assign do_push_c = push & (~full_c | do_pop_c);
  assign drop_c    = push & full_c & ~do_pop_c;
  assign head_c    = mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push_c) - CW'(do_pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cube_move_scheduler.sv
// Key-press to face-rotation scheduler: decode, queue, and launch one move per vblank.
// Optional random scramble generator enabled by defining SCRAMBLE_EN.
module cube_move_scheduler
  import cube_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned SCRAMBLE_LEN = 20
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [7:0]                  keycode,
  input  logic                        Run,
  input  logic                        vblank,
  cube_move_scheduler_if.master       mv,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] queue_count,
  output logic                        overflow
);

  logic [KEY_W-1:0] keycode_prev;
  logic             key_event_c;
  logic             key_push_c;
  logic             esc_c;
  logic             scr_push_c;
  move_t            scr_move_c;
  logic             fifo_push_c;
  logic             fifo_pop_c;
  logic             fifo_full_c;
  logic             fifo_empty_c;
  logic             fifo_drop_c;
  move_t            fifo_din_c;
  move_t            fifo_head_c;
  sched_state_t     state_q;
  sched_state_t     state_d;
  logic             start_d;

  // Edge detect on the keycode so a held key enqueues only once
  always_ff @(posedge Clk) begin
    if (Reset) keycode_prev <= KEY_NONE;
    else       keycode_prev <= keycode;
  end

  assign key_event_c = (keycode != keycode_prev);
  assign key_push_c  = key_event_c & key_is_move(keycode);
  assign esc_c       = key_event_c & (keycode == KEY_ESC);

  assign fifo_push_c = key_push_c | scr_push_c;
  assign fifo_din_c  = key_push_c ? key_to_move(keycode) : scr_move_c;

  move_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_move_fifo (
    .clk     (Clk),
    .rst     (Reset),
    .push    (fifo_push_c),
    .din     (fifo_din_c),
    .pop     (fifo_pop_c),
    .flush   (esc_c),
    .head_c  (fifo_head_c),
    .count   (queue_count),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c),
    .drop_c  (fifo_drop_c)
  );

`ifdef SCRAMBLE_EN
  localparam int unsigned SLW = $clog2(SCRAMBLE_LEN + 1);

  logic [LFSR_W-1:0] lfsr_q;
  logic              run_prev;
  logic              scr_active;
  logic [SLW-1:0]    scr_left;

  // Scramble yields to keyboard pushes and stalls on a full queue instead of dropping
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lfsr_q     <= LFSR_SEED;
      run_prev   <= 1'b0;
      scr_active <= 1'b0;
      scr_left   <= '0;
    end else begin
      lfsr_q   <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
      run_prev <= Run;
      if (esc_c) begin
        scr_active <= 1'b0;
        scr_left   <= '0;
      end else if (Run && !run_prev && !scr_active) begin
        scr_active <= (SCRAMBLE_LEN != 0);
        scr_left   <= SLW'(SCRAMBLE_LEN);
      end else if (scr_push_c) begin
        scr_left <= scr_left - SLW'(1);
        if (scr_left == SLW'(1)) scr_active <= 1'b0;
      end
    end
  end

  assign scr_push_c = scr_active & ~fifo_full_c & ~key_push_c & ~esc_c;
  assign scr_move_c = '{ccw: lfsr_q[3], face: lfsr_face(lfsr_q[2:0])};
`else
  logic unused_run;
  assign unused_run = Run ^ (SCRAMBLE_LEN == 0);
  assign scr_push_c = 1'b0;
  assign scr_move_c = '0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // A done pulse coinciding with the start pulse belongs to no move and is ignored
  always_comb begin
    state_d    = state_q;
    fifo_pop_c = 1'b0;
    start_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_c) state_d = S_WAIT_VB;
      end
      S_WAIT_VB: begin
        if (fifo_empty_c) begin
          state_d = S_IDLE;
        end else if (vblank) begin
          fifo_pop_c = 1'b1;
          start_d    = 1'b1;
          state_d    = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (mv.move_done && !mv.move_start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mv.move_start <= 1'b0;
      mv.move_face  <= U;
      mv.move_ccw   <= 1'b0;
      busy          <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      mv.move_start <= start_d;
      if (start_d) begin
        mv.move_face <= fifo_head_c.face;
        mv.move_ccw  <= fifo_head_c.ccw;
      end
      busy <= (state_d == S_ACTIVE);
      if (esc_c)            overflow <= 1'b0;
      else if (fifo_drop_c) overflow <= 1'b1;
    end
  end

endmodule

// File: doc/cube_move_scheduler.md
Name: cube_move_scheduler

Overview:
Sits between the USB keycode register from the SoC and the cube-state/rotation datapath feeding color_mapper. Turns key presses into face-rotation commands and buffers them in a small FIFO. Issues one move at a time to the datapath with a start/done handshake. Starts a move only during vertical blank, so no rotation is rendered mid-frame.

Parameters:
FIFO_DEPTH, 8, move queue entries (power of two, >=2)
SCRAMBLE_LEN, 20, moves generated per scramble (optional feature only)

Ports:
Clk  input  1  50 MHz system clock (MAX10_CLK1_50)
Reset  input  1  synchronous, active-high reset
keycode  input  8  USB HID keycode from SoC PIO; 0x00 = no key
Run  input  1  scramble request (active-high, level from KEY[1])
vblank  input  1  high while the VGA controller is outside the active region
move_done  input  1  one-cycle pulse from datapath when the current rotation is committed
move_start  output  1  one-cycle pulse launching a rotation
move_face  output  3  face for move_start: 0=U 1=D 2=L 3=R 4=F 5=B
move_ccw  output  1  1 = counter-clockwise, 0 = clockwise
busy  output  1  high from move_start until move_done
queue_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  output  1  sticky: a move was dropped because the FIFO was full

Behaviour:
- Reset: FSM to IDLE; FIFO emptied; move_start=0, move_face=0, move_ccw=0, busy=0, queue_count=0, overflow=0; keycode history register = 0x00.
- Key decode, clockwise: U=0x18, D=0x07, L=0x0F, R=0x15, F=0x09, B=0x05.
- Key decode, counter-clockwise: keys 1..6 (0x1E..0x23) map to U,D,L,R,F,B.
- Press detect: registered keycode_prev.
  - A press event occurs when keycode != keycode_prev and keycode is a valid move code.
  - A held key never re-enqueues. Releasing and re-pressing re-enqueues.
  - A direct change between two valid codes enqueues the new code.
- Escape (0x29) press event: flushes the FIFO (queue_count=0 on the next cycle) and clears overflow. An in-flight move is unaffected.
- FIFO storage: move_t entries, registered.
  - Push when not full, or when full with a pop in the same cycle.
  - A push while full with no pop is dropped and sets overflow.
  - A simultaneous push and pop leaves the count unchanged.
  - Flush has priority over push in the same cycle.
- FSM:
  - IDLE: if queue non-empty, go to WAIT_VB.
  - WAIT_VB: if vblank=1, pop the head, drive move_start=1 for exactly one cycle with move_face/move_ccw from the head, go to ACTIVE. move_face/move_ccw hold until the next move_start.
  - ACTIVE: busy=1; on move_done, busy=0 next cycle, go to IDLE.
  - Latency: a key event to move_start takes a minimum of 3 cycles when the queue is empty and vblank=1 (register keycode, push, IDLE->WAIT_VB, start).
  - move_done outside ACTIVE is ignored.
  - move_done in the same cycle as move_start is not accepted; done is only sampled in ACTIVE.
- Pointers wrap modulo FIFO_DEPTH. queue_count is one bit wider than the pointers so that full is distinguishable from empty.
- Reset mid-move: busy drops, the queue is lost, and no further start is issued. The datapath is reset by the same Reset.

Optional Feature:
Macro SCRAMBLE_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1 at reset) advances every cycle.
  - A rising edge of Run while no scramble is running starts a scramble that enqueues SCRAMBLE_LEN moves.
  - Each move uses face = lfsr[2:0] if <6, else lfsr[2:0]-6; ccw = lfsr[3].
  - One move is enqueued per cycle, only when the FIFO is not full. The scramble stalls rather than dropping, and does not set overflow.
  - A keyboard push in the same cycle has priority; the scramble retries next cycle.
  - Escape aborts the scramble as well as flushing the FIFO.
- Not defined: Run is ignored, no LFSR logic is present, and all other behaviour is identical.

Decomposition:
- Package cube_pkg:
  - typedef enum logic [2:0] face_t {U,D,L,R,F,B}
  - typedef struct packed {logic ccw; face_t face;} move_t
  - keycode localparams, including KEY_ESC = 8'h29
  - LFSR seed and tap constants
- One sub-module: move_fifo (parameterised FIFO_DEPTH, move_t data, push/pop/flush, count, full/empty). Decode, FSM and scramble stay in the top.

Test Plan:
- Reset, keycode 0x00 -> 0x18 -> 0x00 with vblank=1 -> single move_start with face=0, ccw=0 after 3 cycles; busy=1 until move_done; queue_count returns to 0.
- Hold 0x15 for 100 cycles -> exactly one enqueue; then 0x00 -> 0x15 -> a second move R cw.
- vblank=0, press 0x1F -> queue_count=1, no move_start; raise vblank -> start with face=1, ccw=1.
- With move_done withheld, 9 distinct presses into FIFO_DEPTH=8 -> the first move issues and 8 are queued; the 10th press sets overflow=1; Escape -> queue_count=0 and overflow=0 while busy stays 1.
- Push and pop in the same cycle at full -> queue_count stays 8 and no overflow.
- SCRAMBLE_EN: pulse Run -> exactly 20 move_starts, all with face<6; the first face/ccw match the LFSR model from 0xACE1; Reset at move 5 -> busy=0, queue empty, no further move_start.
